// File: rtl/mult_pkg.sv
// Shared types for the shift-add multiplier sequencer: FSM states and
// shift-register select encodings.
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BIT  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_LOAD = 2'b01;
    localparam logic [1:0] SR_SHL  = 2'b10;

    function automatic logic [1:0] onehot2(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mult_rr_arb.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie and flips to the other side whenever a grant is committed via upd.
module mult_rr_arb
    import mult_pkg::*;
(
    input  logic       mult_clk,
    input  logic       mult_rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] win,
    output logic       win_id
);

    logic ptr_r;

    // Winner selection: a lone requester always wins, a tie goes to the pointer
    always_comb begin
        win    = 2'b00;
        win_id = 1'b0;
        case (req)
            2'b01: begin
                win    = 2'b01;
                win_id = 1'b0;
            end
            2'b10: begin
                win    = 2'b10;
                win_id = 1'b1;
            end
            2'b11: begin
                win    = onehot2(ptr_r);
                win_id = ptr_r;
            end
            default: begin
                win    = 2'b00;
                win_id = 1'b0;
            end
        endcase
    end

    // Pointer register: prefer the requester that was not just served
    always_ff @(posedge mult_clk) begin
        if (!mult_rst_n) begin
            ptr_r <= 1'b0;
        end else if (upd && (req != 2'b00)) begin
            ptr_r <= ~win_id;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Sequencer/arbiter for a shared shift-add multiplier datapath.
// Build option MULT_EARLY_EXIT_EN stops the bit loop once no multiplier bits remain.
module mult_sched
    import mult_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic              mult_clk,
    input  logic              mult_rst_n,
    input  logic [1:0]        mult_req,
    input  logic [OP_W-1:0]   mult_a0,
    input  logic [OP_W-1:0]   mult_b0,
    input  logic [OP_W-1:0]   mult_a1,
    input  logic [OP_W-1:0]   mult_b1,
    output logic [1:0]        mult_gnt,
    output logic [OP_W-1:0]   mult_a,
    output logic [1:0]        mult_sr_sel,
    output logic              mult_acc_ld,
    output logic              mult_acc_clr,
    input  logic [2*OP_W-1:0] mult_acc_q,
    output logic              mult_done,
    output logic              mult_done_id,
    output logic [2*OP_W-1:0] mult_p,
    output logic              mult_busy
);

    localparam int CNT_W = $clog2(OP_W);

    state_e            state_r;
    state_e            state_nxt_s;
    logic [1:0]        win_s;
    logic              win_id_s;
    logic              arb_upd_s;
    logic [OP_W-1:0]   win_b_s;
    logic [OP_W-1:0]   b_reg_r;
    logic              id_reg_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              last_bit_s;
    logic              done_r;
    logic              done_id_r;
    logic [2*OP_W-1:0] p_r;

    assign arb_upd_s = (state_r == ST_LOAD);

    mult_rr_arb u_arb (
        .mult_clk   (mult_clk),
        .mult_rst_n (mult_rst_n),
        .req        (mult_req),
        .upd        (arb_upd_s),
        .win        (win_s),
        .win_id     (win_id_s)
    );

    // Operand a is not stored here; it reaches the shift register through this mux
    assign win_b_s = win_id_s ? mult_b1 : mult_b0;
    assign mult_a  = win_id_s ? mult_a1 : mult_a0;

`ifdef MULT_EARLY_EXIT_EN
    logic [OP_W-1:0] rem_s;
    assign rem_s      = b_reg_r >> cnt_r;
    assign last_bit_s = (cnt_r == CNT_W'(OP_W - 1)) || (rem_s[OP_W-1:1] == '0);
`else
    assign last_bit_s = (cnt_r == CNT_W'(OP_W - 1));
`endif

    // State, captured multiplier, requester id and bit counter
    always_ff @(posedge mult_clk) begin
        if (!mult_rst_n) begin
            state_r  <= ST_IDLE;
            b_reg_r  <= '0;
            id_reg_r <= 1'b0;
            cnt_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_LOAD) begin
                b_reg_r  <= win_b_s;
                id_reg_r <= win_id_s;
                cnt_r    <= '0;
            end else if (state_r == ST_BIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Next state and Moore datapath controls
    always_comb begin
        state_nxt_s  = state_r;
        mult_gnt     = 2'b00;
        mult_sr_sel  = SR_HOLD;
        mult_acc_ld  = 1'b0;
        mult_acc_clr = 1'b0;
        mult_busy    = 1'b1;
        case (state_r)
            ST_IDLE: begin
                mult_busy = 1'b0;
                if (mult_req != 2'b00) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                mult_sr_sel  = SR_LOAD;
                mult_acc_clr = 1'b1;
                mult_gnt     = win_s;
                // A request withdrawn before its grant leaves nothing to serve
                if (win_s == 2'b00) begin
                    state_nxt_s = ST_IDLE;
`ifdef MULT_EARLY_EXIT_EN
                end else if (win_b_s == '0) begin
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_BIT;
                end
            end
            ST_BIT: begin
                mult_sr_sel = SR_SHL;
                mult_acc_ld = b_reg_r[cnt_r];
                if (last_bit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_BIT;
                end
            end
            ST_DONE: begin
                if (mult_req != 2'b00) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                mult_busy   = 1'b0;
            end
        endcase
    end

    // Result registers: product and tag update only when a pass completes
    always_ff @(posedge mult_clk) begin
        if (!mult_rst_n) begin
            done_r    <= 1'b0;
            done_id_r <= 1'b0;
            p_r       <= '0;
        end else if (state_r == ST_DONE) begin
            done_r    <= 1'b1;
            done_id_r <= id_reg_r;
            p_r       <= mult_acc_q;
        end else begin
            done_r    <= 1'b0;
            done_id_r <= done_id_r;
            p_r       <= p_r;
        end
    end

    assign mult_done    = done_r;
    assign mult_done_id = done_id_r;
    assign mult_p       = p_r;

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: behavioural shift-add datapath plus a latency/product
// reference model derived from operand values and round-robin history.
module tb_mult_sched;

    localparam int OP_W = 4;

    logic              mult_clk = 1'b0;
    logic              mult_rst_n;
    logic [1:0]        mult_req;
    logic [OP_W-1:0]   mult_a0, mult_b0, mult_a1, mult_b1;
    logic [1:0]        mult_gnt;
    logic [OP_W-1:0]   mult_a;
    logic [1:0]        mult_sr_sel;
    logic              mult_acc_ld, mult_acc_clr;
    logic [2*OP_W-1:0] mult_acc_q;
    logic              mult_done, mult_done_id;
    logic [2*OP_W-1:0] mult_p;
    logic              mult_busy;

    int checks   = 0;
    int failures = 0;
    int ptr_m    = 0;

    logic [2*OP_W-1:0] sr_m  = '0;
    logic [2*OP_W-1:0] acc_m = '0;

    always #5 mult_clk = ~mult_clk;

    mult_sched #(.OP_W(OP_W)) dut (
        .mult_clk     (mult_clk),
        .mult_rst_n   (mult_rst_n),
        .mult_req     (mult_req),
        .mult_a0      (mult_a0),
        .mult_b0      (mult_b0),
        .mult_a1      (mult_a1),
        .mult_b1      (mult_b1),
        .mult_gnt     (mult_gnt),
        .mult_a       (mult_a),
        .mult_sr_sel  (mult_sr_sel),
        .mult_acc_ld  (mult_acc_ld),
        .mult_acc_clr (mult_acc_clr),
        .mult_acc_q   (mult_acc_q),
        .mult_done    (mult_done),
        .mult_done_id (mult_done_id),
        .mult_p       (mult_p),
        .mult_busy    (mult_busy)
    );

    // Shared shift register and accumulator driven by the controls
    always @(posedge mult_clk) begin
        if (mult_sr_sel == 2'b01) sr_m <= {{OP_W{1'b0}}, mult_a};
        else if (mult_sr_sel == 2'b10) sr_m <= sr_m << 1;
        if (mult_acc_clr) acc_m <= '0;
        else if (mult_acc_ld) acc_m <= acc_m + sr_m;
    end
    assign mult_acc_q = acc_m;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycles from request (sampled in IDLE) to done pulse
    function automatic int lat_f(input logic [OP_W-1:0] b);
        int h;
        h = -1;
        for (int i = 0; i < OP_W; i++) if (b[i]) h = i;
`ifdef MULT_EARLY_EXIT_EN
        return (h < 0) ? 3 : 4 + h;
`else
        return (h < OP_W) ? 3 + OP_W : 0;
`endif
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},    16'(mult_gnt),     16'h0);
        chk({tag, "_srsel"},  16'(mult_sr_sel),  16'h0);
        chk({tag, "_accld"},  16'(mult_acc_ld),  16'h0);
        chk({tag, "_accclr"}, 16'(mult_acc_clr), 16'h0);
        chk({tag, "_done"},   16'(mult_done),    16'h0);
        chk({tag, "_doneid"}, 16'(mult_done_id), 16'h0);
        chk({tag, "_p"},      16'(mult_p),       16'h0);
        chk({tag, "_busy"},   16'(mult_busy),    16'h0);
    endtask

    // One request pattern from IDLE through every resulting done pulse
    task automatic run_txn(input logic [1:0] rq, input logic [OP_W-1:0] a0, b0, a1, b1);
        int n, d, gi, k, drop, new_drop, fin;
        int ids[2]; int g[2]; int lat[2];
        logic [OP_W-1:0] ea[2]; logic [OP_W-1:0] eb[2];
        logic [1:0] e_gnt, e_sel; logic e_ld, e_clr;
        mult_a0 = a0; mult_b0 = b0; mult_a1 = a1; mult_b1 = b1;
        mult_req = rq;
        if (rq == 2'b11) begin
            ids[0] = ptr_m; ids[1] = 1 - ptr_m; n = 2;
        end else begin
            ids[0] = rq[1] ? 1 : 0; ids[1] = 0; n = 1;
        end
        for (int j = 0; j < 2; j++) begin
            ea[j]  = ids[j] ? a1 : a0;
            eb[j]  = ids[j] ? b1 : b0;
            lat[j] = lat_f(eb[j]);
        end
        g[0] = 1;
        g[1] = g[0] + lat[0] - 1;
        fin  = g[n-1] - 1 + lat[n-1];
        d = 0; gi = 0; k = 0; drop = -1;
        while (d < n && k < 60) begin
            @(negedge mult_clk);
            k++;
            new_drop = -1;
            e_gnt = 2'b00; e_sel = 2'b00; e_ld = 1'b0; e_clr = 1'b0;
            for (int j = 0; j < n; j++) begin
                if (k == g[j]) begin
                    e_gnt = ids[j] ? 2'b10 : 2'b01;
                    e_sel = 2'b01;
                    e_clr = 1'b1;
                end else if (k > g[j] && k <= g[j] + lat[j] - 3) begin
                    e_sel = 2'b10;
                    e_ld  = eb[j][k - g[j] - 1];
                end
            end
            chk("gnt",    16'(mult_gnt),     16'(e_gnt));
            chk("sr_sel", 16'(mult_sr_sel),  16'(e_sel));
            chk("acc_ld", 16'(mult_acc_ld),  16'(e_ld));
            chk("acc_clr",16'(mult_acc_clr), 16'(e_clr));
            chk("busy",   16'(mult_busy),    16'(k < fin));
            if (gi < n && k == g[gi]) begin
                new_drop = ids[gi];
                ptr_m = 1 - ids[gi];
                gi++;
            end
            chk("done", 16'(mult_done), 16'(d < n && k == g[d] - 1 + lat[d]));
            if (d < n && k == g[d] - 1 + lat[d]) begin
                chk("product", 16'(mult_p),       16'(ea[d] * eb[d]));
                chk("done_id", 16'(mult_done_id), 16'(ids[d]));
                d++;
            end
            if (drop >= 0) mult_req[drop] = 1'b0;
            drop = new_drop;
        end
        if (drop >= 0) mult_req[drop] = 1'b0;
        chk("txn_timeout", 16'(d), 16'(n));
    endtask

    initial begin
        mult_rst_n = 1'b0;
        mult_req = 2'b00;
        mult_a0 = '0; mult_b0 = '0; mult_a1 = '0; mult_b1 = '0;
        repeat (3) @(negedge mult_clk);
        chk_idle_outputs("reset");
        mult_rst_n = 1'b1;

        run_txn(2'b01, 4'd3, 4'd5, 4'd0, 4'd0);
        run_txn(2'b10, 4'd0, 4'd0, 4'd15, 4'd15);
        run_txn(2'b11, 4'd2, 4'd7, 4'd6, 4'd3);
        run_txn(2'b01, 4'd9, 4'd0, 4'd0, 4'd0);
        run_txn(2'b01, 4'd7, 4'd2, 4'd0, 4'd0);
        run_txn(2'b01, 4'd0, 4'd11, 4'd0, 4'd0);

        // Reset asserted during the second bit cycle of a pass
        mult_a0 = 4'd9; mult_b0 = 4'd15; mult_req = 2'b01;
        @(negedge mult_clk);
        chk("rst_gnt", 16'(mult_gnt), 16'h1);
        @(negedge mult_clk);
        mult_req = 2'b00;
        @(negedge mult_clk);
        chk("rst_busy_pre", 16'(mult_busy), 16'h1);
        mult_rst_n = 1'b0;
        @(negedge mult_clk);
        chk_idle_outputs("midrst");
        mult_rst_n = 1'b1;
        ptr_m = 0;
        run_txn(2'b01, 4'd4, 4'd4, 4'd0, 4'd0);

        // Pointer returns to requester 0 after reset
        mult_rst_n = 1'b0;
        @(negedge mult_clk);
        mult_rst_n = 1'b1;
        ptr_m = 0;
        run_txn(2'b10, 4'd1, 4'd1, 4'd5, 4'd5);
        mult_rst_n = 1'b0;
        @(negedge mult_clk);
        mult_rst_n = 1'b1;
        ptr_m = 0;
        run_txn(2'b11, 4'd3, 4'd3, 4'd2, 4'd2);

        for (int i = 0; i < 40; i++) begin
            run_txn(2'($urandom_range(1, 3)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if (($urandom & 32'd3) == 32'd0) @(negedge mult_clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
